fpu_sqrt_core: RTL and testbench

FPU_SQRT_CORE -- requirements
Module: fpu_sqrt_core

---
 rtl/fpu_sqrt_pkg.sv | 16 +
 rtl/fpu_sqrt_core_sqrt_step.sv | 29 ++
 rtl/fpu_sqrt_core.sv | 96 +++++++++
 tb/tb_fpu_sqrt_core.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sqrt_pkg.sv
// Shared constants and FSM encoding for the significand square-root core.
package fpu_sqrt_pkg;

  // Default root width; the radicand is twice this wide.
  localparam int ROOT_W_DEF = 44;
  localparam int RAD_W      = 2 * ROOT_W_DEF;  // 88
  localparam int SIG_W      = 24;              // significand incl. hidden bit
  localparam int CNT_W      = 6;               // iteration counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_t;

endpackage

// File: rtl/fpu_sqrt_core_sqrt_step.sv
// One restoring radix-2 square-root step: shifts two radicand bits into the
// remainder, trial-subtracts {root, 01} and appends the resulting root bit.
module sqrt_step #(
  parameter int ROOT_W = 44
) (
  input  logic [ROOT_W+1:0] rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        rad_bits,
  output logic [ROOT_W+1:0] rem_next,
  output logic [ROOT_W-1:0] root_next
);

  logic [ROOT_W+1:0] shifted;
  logic [ROOT_W+2:0] trial;

  // Trial subtraction with an extra sign bit; a clear sign means the root bit is 1.
  always_comb begin
    shifted = (rem << 2) | {{ROOT_W{1'b0}}, rad_bits};
    trial   = {1'b0, shifted} - {1'b0, root, 2'b01};
    if (!trial[ROOT_W+2]) begin
      rem_next  = trial[ROOT_W+1:0];
      root_next = (root << 1) | {{(ROOT_W-1){1'b0}}, 1'b1};
    end else begin
      rem_next  = shifted;
      root_next = root << 1;
    end
  end

endmodule

// File: rtl/fpu_sqrt_core.sv
// Iterative significand square root: floor(sqrt(radicand)) one bit per cycle,
// MSB first, with a nonzero-remainder flag for rounding stickiness.
module fpu_sqrt_core
  import fpu_sqrt_pkg::*;
#(
  parameter int ROOT_W = ROOT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_exp_odd,
  input  logic [SIG_W-1:0]  in_sig,
  output logic              sqrt_done,
  output logic [ROOT_W-1:0] sqrt_sig,
  output logic              rem_nz
);

  localparam int RW  = 2 * ROOT_W;
  localparam int PAD = RW - SIG_W;

  sqrt_state_t       state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [RW-1:0]     rad_reg;
  logic [ROOT_W+1:0] rem_reg;
  logic [ROOT_W-1:0] root_reg;
  logic              sqrt_done_reg;
  logic [ROOT_W-1:0] sqrt_sig_reg;
  logic              rem_nz_reg;

  logic [RW-1:0]     rad_load;
  logic              accept;
  logic [ROOT_W+1:0] rem_next;
  logic [ROOT_W-1:0] root_next;

  // Odd exponents use the significand as-is; even ones halve it so the
  // exponent can be halved exactly.
  always_comb begin
    rad_load = is_exp_odd ? {in_sig, {PAD{1'b0}}}
                          : {1'b0, in_sig, {(PAD-1){1'b0}}};
    accept   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  end

  sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .rem       (rem_reg),
    .root      (root_reg),
    .rad_bits  (rad_reg[RW-1 -: 2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // Control FSM and iteration datapath; results latch when the last bit is formed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rad_reg       <= '0;
      rem_reg       <= '0;
      root_reg      <= '0;
      sqrt_done_reg <= 1'b0;
      sqrt_sig_reg  <= '0;
      rem_nz_reg    <= 1'b0;
    end else begin
      sqrt_done_reg <= 1'b0;
      if (accept) begin
        rad_reg   <= rad_load;
        rem_reg   <= '0;
        root_reg  <= '0;
        cnt_reg   <= CNT_W'(ROOT_W - 1);
        state_reg <= ST_BUSY;
      end else begin
        case (state_reg)
          ST_BUSY: begin
            rem_reg  <= rem_next;
            root_reg <= root_next;
            rad_reg  <= rad_reg << 2;
            if (cnt_reg == '0) begin
              state_reg     <= ST_DONE;
              sqrt_done_reg <= 1'b1;
              sqrt_sig_reg  <= root_next;
              rem_nz_reg    <= |rem_next;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign sqrt_done = sqrt_done_reg;
  assign sqrt_sig  = sqrt_sig_reg;
  assign rem_nz    = rem_nz_reg;

endmodule

// File: tb/tb_fpu_sqrt_core.sv
// Directed and random checks of fpu_sqrt_core against an integer-sqrt model.
module tb_fpu_sqrt_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_exp_odd = 1'b0;
  logic [23:0] in_sig = '0;
  logic        sqrt_done;
  logic [43:0] sqrt_sig;
  logic        rem_nz;

  int checks = 0;
  int errors = 0;

  fpu_sqrt_core #(.ROOT_W(44)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_exp_odd (is_exp_odd),
    .in_sig     (in_sig),
    .sqrt_done  (sqrt_done),
    .sqrt_sig   (sqrt_sig),
    .rem_nz     (rem_nz)
  );

  always #5 clk = ~clk;

  // Reference: radicand as sig*2^64 (odd) or sig*2^63 (even), root by binary search.
  function automatic logic [87:0] ref_rad(input logic [23:0] sig, input logic odd);
    logic [87:0] r;
    r = {64'b0, sig};
    return odd ? (r << 64) : (r << 63);
  endfunction

  function automatic logic [43:0] ref_root(input logic [87:0] rad);
    logic [44:0] lo, hi, mid;
    logic [89:0] sq;
    lo = '0;
    hi = 45'h1 << 44;
    while (hi - lo > 45'd1) begin
      mid = (lo + hi) >> 1;
      sq  = {45'b0, mid} * {45'b0, mid};
      if (sq <= {2'b0, rad}) lo = mid;
      else hi = mid;
    end
    return lo[43:0];
  endfunction

  function automatic logic ref_nz(input logic [87:0] rad);
    logic [89:0] sq;
    logic [43:0] r;
    r  = ref_root(rad);
    sq = {46'b0, r} * {46'b0, r};
    return sq != {2'b0, rad};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands for one edge, then scramble them.
  task automatic launch(input logic [23:0] sig, input logic odd);
    start = 1'b1;
    in_sig = sig;
    is_exp_odd = odd;
    @(negedge clk);
    start = 1'b0;
    in_sig = 24'($urandom);
    is_exp_odd = 1'($urandom);
  endtask

  // n counts cycles from the accepting edge; the result cycle should be 45.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (sqrt_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_res(input string tag, input logic [23:0] sig, input logic odd,
                           input logic [43:0] exp_root, input logic exp_nz, input int n);
    $display("op %s in_sig=%h odd=%0d sqrt_sig=%h rem_nz=%0d cycle=%0d",
             tag, sig, odd, sqrt_sig, rem_nz, n);
    chk({tag, "_root"}, 64'(sqrt_sig), 64'(exp_root));
    chk({tag, "_nz"}, 64'(rem_nz), 64'(exp_nz));
    chk({tag, "_lat"}, 64'(n), 64'd45);
  endtask

  initial begin
    int n;
    int stray;
    logic [23:0] sig;
    logic odd;
    logic [87:0] rad;

    // Reset state
    @(negedge clk);
    chk("rst_done", 64'(sqrt_done), 64'd0);
    chk("rst_sig", 64'(sqrt_sig), 64'd0);
    chk("rst_nz", 64'(rem_nz), 64'd0);

    // Start on the first edge after reset release; exact power of two
    reset = 1'b1;
    launch(24'h800000, 1'b0);
    wait_done(1, n);
    check_res("pow2_even", 24'h800000, 1'b0, 44'h80000000000, 1'b0, n);
    @(negedge clk);
    chk("done_pulse", 64'(sqrt_done), 64'd0);

    // Root two, inexact
    launch(24'h800000, 1'b1);
    wait_done(1, n);
    check_res("sqrt2", 24'h800000, 1'b1, 44'hB504F333F9D, 1'b1, n);
    @(negedge clk);
    // Result holds while idle and inputs wander
    for (int i = 0; i < 5; i++) begin
      in_sig = 24'($urandom);
      @(negedge clk);
    end
    chk("hold_sig", 64'(sqrt_sig), 64'hB504F333F9D);
    chk("hold_nz", 64'(rem_nz), 64'd1);

    // Exact 1.125 * 2 -> 1.5
    launch(24'h900000, 1'b1);
    wait_done(1, n);
    check_res("exact15", 24'h900000, 1'b1, 44'hC0000000000, 1'b0, n);
    @(negedge clk);

    // Smallest subnormal
    launch(24'h000001, 1'b0);
    wait_done(1, n);
    check_res("subnorm", 24'h000001, 1'b0, 44'h000B504F333, 1'b1, n);
    @(negedge clk);

    // Zero operand
    launch(24'h000000, 1'b1);
    wait_done(1, n);
    check_res("zero", 24'h000000, 1'b1, 44'h0, 1'b0, n);
    @(negedge clk);

    // start re-pulsed in BUSY cycle 10 is ignored
    launch(24'h800000, 1'b1);
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    start = 1'b1; in_sig = 24'h900000; is_exp_odd = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    wait_done(n, n);
    check_res("busy_start", 24'h800000, 1'b1, 44'hB504F333F9D, 1'b1, n);
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sqrt_done === 1'b1) stray++;
    end
    chk("no_queue", 64'(stray), 64'd0);

    // Back-to-back: new start in the DONE cycle
    launch(24'h900000, 1'b1);
    wait_done(1, n);
    check_res("b2b_first", 24'h900000, 1'b1, 44'hC0000000000, 1'b0, n);
    launch(24'h000001, 1'b0);
    wait_done(1, n);
    check_res("b2b_second", 24'h000001, 1'b0, 44'h000B504F333, 1'b1, n);
    @(negedge clk);

    // Reset in BUSY cycle 20 clears outputs at once and abandons the op
    launch(24'h800000, 1'b1);
    n = 1;
    while (n < 20) begin @(negedge clk); n++; end
    reset = 1'b0;
    #1;
    chk("arst_sig", 64'(sqrt_sig), 64'd0);
    chk("arst_nz", 64'(rem_nz), 64'd0);
    chk("arst_done", 64'(sqrt_done), 64'd0);
    @(negedge clk);
    chk("arst_hold", 64'(sqrt_sig), 64'd0);
    reset = 1'b1;
    rad = ref_rad(24'h900000, 1'b0);
    launch(24'h900000, 1'b0);
    wait_done(1, n);
    check_res("post_rst", 24'h900000, 1'b0, ref_root(rad), ref_nz(rad), n);
    @(negedge clk);

    // Random regression against the integer-sqrt model
    for (int i = 0; i < 24; i++) begin
      sig = 24'($urandom);
      if (i % 3 == 0) sig = sig >> $urandom_range(1, 23);
      else sig[23] = 1'b1;
      odd = 1'($urandom);
      rad = ref_rad(sig, odd);
      launch(sig, odd);
      wait_done(1, n);
      check_res($sformatf("rnd%0d", i), sig, odd, ref_root(rad), ref_nz(rad), n);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
